// File: rtl/pulse_train_pkg.sv
// Shared definitions for the pulse train generator.
//   chan_state_e : per-channel FSM state encoding
//   norm_len     : maps a programmed phase length of 0 onto 1 cycle
package pulse_train_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHigh = 2'd1,
    StLow  = 2'd2
  } chan_state_e;

  function automatic int unsigned norm_len(input int unsigned len);
    return (len == 0) ? 1 : len;
  endfunction

endpackage

// File: rtl/pulse_train_chan.sv
// One pulse train channel: FSM, phase down-counter, remaining-pulse counter.
// Optional build macro PULSE_TRAIN_SYNC_EN inserts 2-flop synchronisers on start/stop.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   start_i, stop_i   start/stop requests (stop wins)
//   cont_i            1 = continuous, 0 = one-shot of num_pulses_i pulses
//   high_len_i        high phase length in cycles (0 treated as 1)
//   low_len_i         low phase length in cycles (0 treated as 1)
//   num_pulses_i      pulse count for one-shot trains
//   pulse_o, busy_o   pulse output, channel running
//   done_o            one-cycle strobe on normal one-shot completion
module pulse_train_chan
  import pulse_train_pkg::*;
#(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned NUM_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             cont_i,
  input  logic [CNT_W-1:0] high_len_i,
  input  logic [CNT_W-1:0] low_len_i,
  input  logic [NUM_W-1:0] num_pulses_i,
  output logic             pulse_o,
  output logic             busy_o,
  output logic             done_o
);

  logic start_s;
  logic stop_s;

`ifdef PULSE_TRAIN_SYNC_EN
  logic [1:0] start_sync_q;
  logic [1:0] stop_sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_sync_q <= '0;
      stop_sync_q  <= '0;
    end else begin
      start_sync_q <= {start_sync_q[0], start_i};
      stop_sync_q  <= {stop_sync_q[0], stop_i};
    end
  end

  assign start_s = start_sync_q[1];
  assign stop_s  = stop_sync_q[1];
`else
  assign start_s = start_i;
  assign stop_s  = stop_i;
`endif

  // Phase counter holds the cycles remaining after the current one.
  function automatic logic [CNT_W-1:0] reload(input logic [CNT_W-1:0] len);
    return CNT_W'(norm_len(32'(len)) - 32'd1);
  endfunction

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [NUM_W-1:0] left_q, left_d;
  logic             cont_q, cont_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic             done_q, done_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      phase_q <= '0;
      left_q  <= '0;
      cont_q  <= 1'b0;
      high_q  <= '0;
      low_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      left_q  <= left_d;
      cont_q  <= cont_d;
      high_q  <= high_d;
      low_q   <= low_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    left_d  = left_q;
    cont_d  = cont_q;
    high_d  = high_q;
    low_d   = low_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_s && !stop_s) begin
          cont_d = cont_i;
          high_d = high_len_i;
          low_d  = low_len_i;
          left_d = num_pulses_i;
          if (!cont_i && (num_pulses_i == '0)) begin
            // Empty one-shot train: report completion without ever going busy.
            done_d = 1'b1;
          end else begin
            state_d = StHigh;
            phase_d = reload(high_len_i);
          end
        end
      end
      StHigh: begin
        if (stop_s) begin
          state_d = StIdle;
          phase_d = '0;
        end else if (phase_q != '0) begin
          phase_d = phase_q - 1'b1;
        end else if (!cont_q && (left_q == NUM_W'(1))) begin
          // Last pulse of a one-shot train: skip the trailing low phase.
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          state_d = StLow;
          phase_d = reload(low_q);
          if (!cont_q) begin
            left_d = left_q - 1'b1;
          end
        end
      end
      StLow: begin
        if (stop_s) begin
          state_d = StIdle;
          phase_d = '0;
        end else if (phase_q != '0) begin
          phase_d = phase_q - 1'b1;
        end else begin
          state_d = StHigh;
          phase_d = reload(high_q);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    pulse_o = (state_q == StHigh);
    busy_o  = (state_q != StIdle);
    done_o  = done_q;
  end

endmodule

// File: rtl/pulse_train_gen.sv
// Multi-channel programmable pulse train generator; CHANNELS independent copies of
// pulse_train_chan. Optional build macro PULSE_TRAIN_SYNC_EN adds input synchronisers.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   start_i         per-channel start request
//   stop_i          per-channel stop request
//   cont_i          per-channel continuous-mode select
//   high_len_i      per-channel high length, ch i at [i*CNT_W +: CNT_W]
//   low_len_i       per-channel low length, ch i at [i*CNT_W +: CNT_W]
//   num_pulses_i    per-channel pulse count, ch i at [i*NUM_W +: NUM_W]
//   pulse_o         per-channel pulse outputs
//   busy_o          per-channel running flags
//   done_o          per-channel one-shot completion strobes
module pulse_train_gen
  import pulse_train_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned NUM_W    = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [CHANNELS-1:0]       start_i,
  input  logic [CHANNELS-1:0]       stop_i,
  input  logic [CHANNELS-1:0]       cont_i,
  input  logic [CHANNELS*CNT_W-1:0] high_len_i,
  input  logic [CHANNELS*CNT_W-1:0] low_len_i,
  input  logic [CHANNELS*NUM_W-1:0] num_pulses_i,
  output logic [CHANNELS-1:0]       pulse_o,
  output logic [CHANNELS-1:0]       busy_o,
  output logic [CHANNELS-1:0]       done_o
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    pulse_train_chan #(
      .CNT_W(CNT_W),
      .NUM_W(NUM_W)
    ) u_chan (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .start_i     (start_i[i]),
      .stop_i      (stop_i[i]),
      .cont_i      (cont_i[i]),
      .high_len_i  (high_len_i[i*CNT_W +: CNT_W]),
      .low_len_i   (low_len_i[i*CNT_W +: CNT_W]),
      .num_pulses_i(num_pulses_i[i*NUM_W +: NUM_W]),
      .pulse_o     (pulse_o[i]),
      .busy_o      (busy_o[i]),
      .done_o      (done_o[i])
    );
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench for pulse_train_gen: stimulus pushes per-cycle expected
// pulse/busy/done values tagged with the cycle they apply to; a negedge monitor
// pops and compares them against the DUT.
module tb_pulse_train_gen;

`ifdef PULSE_TRAIN_SYNC_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  start;
  logic [3:0]  stop;
  logic [3:0]  cont;
  logic [31:0] high_len;
  logic [31:0] low_len;
  logic [15:0] num_pulses;
  logic [3:0]  pulse;
  logic [3:0]  busy;
  logic [3:0]  done;

  pulse_train_gen #(
    .CHANNELS(4),
    .CNT_W   (8),
    .NUM_W   (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .stop_i      (stop),
    .cont_i      (cont),
    .high_len_i  (high_len),
    .low_len_i   (low_len),
    .num_pulses_i(num_pulses),
    .pulse_o     (pulse),
    .busy_o      (busy),
    .done_o      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int    tag;
    int    ch;
    logic  p;
    logic  b;
    logic  d;
    string name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation whose cycle tag matches now.
  always @(negedge clk) begin
    int add_vec;
    int add_bad;
    add_vec = 0;
    add_bad = 0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].tag <= cyc) begin
        add_vec++;
        if (q[i].tag < cyc) begin
          add_bad++;
          $display("FAIL %s ch%0d: expectation for cycle %0d never sampled (now %0d)",
                   q[i].name, q[i].ch, q[i].tag, cyc);
        end else if ({pulse[q[i].ch], busy[q[i].ch], done[q[i].ch]} !==
                     {q[i].p, q[i].b, q[i].d}) begin
          add_bad++;
          $display("FAIL %s ch%0d cycle %0d: pulse/busy/done got %b%b%b want %b%b%b",
                   q[i].name, q[i].ch, q[i].tag, pulse[q[i].ch], busy[q[i].ch],
                   done[q[i].ch], q[i].p, q[i].b, q[i].d);
        end
        q.delete(i);
      end
    end
    n_vec <= n_vec + add_vec;
    n_bad <= n_bad + add_bad;
  end

  // Vectors are written cycle 1 leftmost: bit [len-k] is cycle k after the start edge.
  task automatic expect_ch(input string name, input int ch, input int base, input int len,
                           input logic [31:0] p, input logic [31:0] b, input logic [31:0] d);
    exp_t e;
    for (int k = 1; k <= len; k++) begin
      e.tag  = base + k;
      e.ch   = ch;
      e.p    = p[len-k];
      e.b    = b[len-k];
      e.d    = d[len-k];
      e.name = name;
      q.push_back(e);
    end
  endtask

  task automatic cfg(input int ch, input logic c, input int h, input int l, input int n);
    cont[ch]             = c;
    high_len[ch*8 +: 8]  = 8'(h);
    low_len[ch*8 +: 8]   = 8'(l);
    num_pulses[ch*4 +: 4] = 4'(n);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int base;

  initial begin
    rst_n      = 1'b0;
    start      = '0;
    stop       = '0;
    cont       = '0;
    high_len   = '0;
    low_len    = '0;
    num_pulses = '0;
    for (int c = 0; c < 4; c++) expect_ch("reset", c, 0, 3, 0, 0, 0);
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // One-shot H=3 L=2 N=2.
    cfg(0, 1'b0, 3, 2, 2);
    start[0] = 1'b1;
    base = cyc + Lat;
    expect_ch("oneshot", 0, base, 10, 10'b1110011100, 10'b1111111100, 10'b0000000010);
    tick(1);
    start[0] = 1'b0;
    tick(12);

    // Continuous H=1 L=1, stopped after 20 cycles.
    cfg(1, 1'b1, 1, 1, 0);
    start[1] = 1'b1;
    base = cyc + Lat;
    expect_ch("cont_stop", 1, base, 22, 22'b1010101010101010101000,
              22'b1111111111111111111100, 22'b0);
    tick(1);
    start[1] = 1'b0;
    tick(19);
    stop[1] = 1'b1;
    tick(1);
    stop[1] = 1'b0;
    tick(4);

    // Stop beats start in the same cycle.
    start[1] = 1'b1;
    stop[1]  = 1'b1;
    base = cyc + Lat;
    expect_ch("stop_prio", 1, base, 3, 0, 0, 0);
    tick(1);
    start[1] = 1'b0;
    stop[1]  = 1'b0;
    tick(4);

    // Zero lengths behave as 1.
    cfg(2, 1'b0, 0, 0, 3);
    start[2] = 1'b1;
    base = cyc + Lat;
    expect_ch("zero_len", 2, base, 7, 7'b1010100, 7'b1111100, 7'b0000010);
    tick(1);
    start[2] = 1'b0;
    tick(8);

    // Empty one-shot train.
    cfg(2, 1'b0, 3, 3, 0);
    start[2] = 1'b1;
    base = cyc + Lat;
    expect_ch("num_zero", 2, base, 3, 3'b000, 3'b000, 3'b100);
    tick(1);
    start[2] = 1'b0;
    tick(4);

    // All channels at once, different settings.
    cfg(0, 1'b0, 2, 1, 2);
    cfg(1, 1'b0, 1, 3, 2);
    cfg(2, 1'b0, 4, 0, 1);
    cfg(3, 1'b1, 1, 2, 0);
    start = 4'hf;
    base = cyc + Lat;
    expect_ch("multi", 0, base, 7, 7'b1101100, 7'b1111100, 7'b0000010);
    expect_ch("multi", 1, base, 7, 7'b1000100, 7'b1111100, 7'b0000010);
    expect_ch("multi", 2, base, 7, 7'b1111000, 7'b1111000, 7'b0000100);
    expect_ch("multi", 3, base, 7, 7'b1001001, 7'b1111111, 7'b0);
    tick(1);
    start = '0;
    tick(8);
    stop[3] = 1'b1;
    base = cyc + Lat;
    expect_ch("multi_stop", 3, base, 2, 0, 0, 0);
    tick(1);
    stop[3] = 1'b0;
    tick(3);

    // Asynchronous reset in the middle of a high phase.
    cfg(0, 1'b0, 5, 1, 1);
    start[0] = 1'b1;
    base = cyc + Lat;
    expect_ch("async_rst", 0, base, 7, 7'b1100000, 7'b1100000, 7'b0);
    for (int c = 1; c < 4; c++) expect_ch("async_rst", c, base + 2, 1, 0, 0, 0);
    tick(1);
    start[0] = 1'b0;
    tick(Lat + 2);
    #1;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(4);

    // Start held high: back-to-back one-shots, mid-train config change ignored.
    cfg(3, 1'b0, 2, 0, 1);
    start[3] = 1'b1;
    base = cyc + Lat;
    expect_ch("back2back", 3, base, 10, 10'b1101101100, 10'b1101101100, 10'b0010010010);
    tick(2 + Lat);
    cfg(3, 1'b1, 7, 4, 5);
    tick(1);
    cfg(3, 1'b0, 2, 0, 1);
    tick(4 - Lat);
    start[3] = 1'b0;
    tick(8);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
